matmul_grid_mem_ctrl: RTL and testbench
=======================================

MATMUL_GRID_MEM_CTRL -- requirements
Module: matmul_grid_mem_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter MAT_SIZE, default 16, building-block matmul dimension; memory word = MAT_SIZE*DWIDTH bits (W).
REQ-003 SHALL have parameter AWIDTH, default 7, BRAM address width.
REQ-004 SHALL have parameter GRID, default 2, tiles per side (2..8); banks per matrix = GRID; BW = max(1, clog2(GRID)).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  run request, sampled in IDLE only.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse at run completion.
REQ-011 err  out  2  sticky: bit0 host write while busy, bit1 watchdog timeout.
REQ-012 host_we  in  1  host write strobe.
REQ-013 host_sel  in  2  target: 0=A, 1=B, 2=C readback, 3=none.
REQ-014 host_bank  in  BW  bank index.
REQ-015 host_addr  in  AWIDTH  host word address.
REQ-016 host_wdata  in  W  host write data.
REQ-017 host_rdata  out  W  C readback data.
REQ-018 host_rvalid  out  1  qualifies host_rdata.
REQ-019 a_addr, b_addr, c_addr  out  GRID*AWIDTH each  per-bank registered addresses.
REQ-020 a_we, b_we  out  GRID each  per-bank write enables; mem_wdata  out  W  registered copy of host_wdata.
REQ-021 c_rdata  in  GRID*W  per-bank C BRAM read data (1-cycle BRAM latency).
REQ-022 array_start  out  1  level start to systolic grid; array_done  in  1  completion from grid.

Function
REQ-023 FSM states SHALL be IDLE, STREAM, WAIT, DRAIN; all address/we outputs registered (1 cycle after decision).
REQ-024 IDLE: host_we with host_sel 0/1 SHALL assert a_we/b_we only for host_bank, with that bank's address = host_addr, mem_wdata = host_wdata, next cycle.
REQ-025 IDLE, start=1 SHALL move to STREAM next cycle; start and host_we together: write performed, start honoured.
REQ-026 STREAM: array_start=1; bank i address SHALL be held at MEM_SIZE-1 (all ones) for i cycles of skew, then count 0..MAT_SIZE-1, then hold all ones; STREAM lasts MAT_SIZE+GRID-1 cycles, then WAIT.
REQ-027 WAIT: array_start stays 1; on array_done=1 go to DRAIN next cycle.
REQ-028 DRAIN: c_we[i] and c_addr bank i SHALL count 0..MAT_SIZE-1 with same skew as REQ-026; after MAT_SIZE+GRID-1 cycles: done=1 for one cycle, array_start=0, return to IDLE.
REQ-029 Counters wrap-free: address counters saturate at MAT_SIZE-1; MAT_SIZE > 2^AWIDTH is a configuration error, out of scope.
REQ-030 host_we while busy SHALL be ignored (no a_we/b_we) and set err[0].
REQ-031 Readback: in IDLE, host_sel=2 SHALL drive c_addr[host_bank]=host_addr; host_rdata = c_rdata slice host_bank, registered; host_rvalid=1 exactly 2 cycles after the request cycle; other banks' data never ORed in.
REQ-032 host_sel=2 requests while busy SHALL produce no host_rvalid.
REQ-033 err bits SHALL clear only on reset or on start accepted in IDLE.

Reset
REQ-034 reset low SHALL immediately force IDLE, busy=0, done=0, err=0, array_start=0, host_rvalid=0, host_rdata=0, all we=0, all addresses all ones; mid-run reset abandons the run with no done pulse.

Configuration
REQ-035 Macro MATMUL_GRID_WATCHDOG_EN defined: WAIT counts cycles; reaching 1024 without array_done SHALL set err[1], deassert array_start, return to IDLE with no done. Undefined: no counter, WAIT unbounded, err[1] constant 0.

Verification
REQ-036 GRID=2, MAT_SIZE=16: host writes A bank1 addr 5 = 0x..A5 -> a_we=2'b10, a_addr bank1=5 next cycle, bank0 we=0.
REQ-037 start pulse -> busy next cycle; bank0 address 0 one cycle after STREAM entry, bank1 address 0 one cycle later; STREAM 17 cycles.
REQ-038 array_done asserted 30 cycles into WAIT -> DRAIN 17 cycles, c_we skewed per bank, single done pulse, busy=0 after.
REQ-039 C readback bank1 addr 3 with c_rdata bank1=0x1234.., bank0=0xFFFF.. -> host_rvalid 2 cycles later, host_rdata=0x1234.. only.
REQ-040 host_we during STREAM -> no a_we/b_we, err=2'b01 until next accepted start; reset low mid-WAIT -> all outputs at reset values same cycle, no done.
REQ-041 With MATMUL_GRID_WATCHDOG_EN, array_done never asserted -> err[1]=1 after 1024 WAIT cycles, IDLE, no done; without macro -> still busy at 2000 cycles.

Source files
------------

// File: rtl/matmul_grid_mem_ctrl.sv
// BRAM address/write-enable sequencer for a GRID x GRID systolic matmul: host load, skewed A/B streaming, skewed C drain, C readback.
// Define MATMUL_GRID_WATCHDOG_EN to bound the WAIT state to 1024 cycles (err[1] on expiry).
module matmul_grid_mem_ctrl #(
    parameter int DWIDTH   = 8,
    parameter int MAT_SIZE = 16,
    parameter int AWIDTH   = 7,
    parameter int GRID     = 2,
    localparam int W       = MAT_SIZE * DWIDTH,
    localparam int BW      = (GRID > 2) ? $clog2(GRID) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err,
    input  logic                   host_we,
    input  logic [1:0]             host_sel,
    input  logic [BW-1:0]          host_bank,
    input  logic [AWIDTH-1:0]      host_addr,
    input  logic [W-1:0]           host_wdata,
    output logic [W-1:0]           host_rdata,
    output logic                   host_rvalid,
    output logic [GRID*AWIDTH-1:0] a_addr,
    output logic [GRID*AWIDTH-1:0] b_addr,
    output logic [GRID*AWIDTH-1:0] c_addr,
    output logic [GRID-1:0]        a_we,
    output logic [GRID-1:0]        b_we,
    output logic [GRID-1:0]        c_we,
    output logic [W-1:0]           mem_wdata,
    input  logic [GRID*W-1:0]      c_rdata,
    output logic                   array_start,
    input  logic                   array_done
);

    localparam int STEPS = MAT_SIZE + GRID - 1;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   step;
    logic            rd_pend;
    logic [BW-1:0]   rd_bank;
`ifdef MATMUL_GRID_WATCHDOG_EN
    logic [9:0]      wdog;
`endif

    // Bank b is offset by b steps so rows enter the array diagonally.
    function automatic logic [AWIDTH-1:0] skew_addr(input logic [CW-1:0] s, input int bank);
        int off;
        off = int'(s) - bank;
        if (off >= 0 && off < MAT_SIZE) return off[AWIDTH-1:0];
        return '1;
    endfunction

    function automatic logic skew_hit(input logic [CW-1:0] s, input int bank);
        int off;
        off = int'(s) - bank;
        return (off >= 0 && off < MAT_SIZE);
    endfunction

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            step        <= '0;
            done        <= 1'b0;
            err         <= 2'b00;
            array_start <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
            rd_pend     <= 1'b0;
            rd_bank     <= '0;
            a_we        <= '0;
            b_we        <= '0;
            c_we        <= '0;
            a_addr      <= '1;
            b_addr      <= '1;
            c_addr      <= '1;
            mem_wdata   <= '0;
`ifdef MATMUL_GRID_WATCHDOG_EN
            wdog        <= '0;
`endif
        end else begin
            a_we        <= '0;
            b_we        <= '0;
            c_we        <= '0;
            a_addr      <= '1;
            b_addr      <= '1;
            c_addr      <= '1;
            done        <= 1'b0;
            mem_wdata   <= host_wdata;
            rd_pend     <= 1'b0;
            host_rvalid <= rd_pend;

            // c_addr acts as the BRAM address register, so c_rdata is valid one cycle after it.
            if (rd_pend) begin
                for (int i = 0; i < GRID; i++) begin
                    if (rd_bank == BW'(i)) host_rdata <= c_rdata[i*W +: W];
                end
            end

            if (busy && host_we) err[0] <= 1'b1;

            case (state)
                S_IDLE: begin
                    for (int i = 0; i < GRID; i++) begin
                        if (host_bank == BW'(i)) begin
                            if (host_we && host_sel == 2'd0) begin
                                a_we[i]                   <= 1'b1;
                                a_addr[i*AWIDTH +: AWIDTH] <= host_addr;
                            end
                            if (host_we && host_sel == 2'd1) begin
                                b_we[i]                   <= 1'b1;
                                b_addr[i*AWIDTH +: AWIDTH] <= host_addr;
                            end
                            if (host_sel == 2'd2) c_addr[i*AWIDTH +: AWIDTH] <= host_addr;
                        end
                    end
                    if (host_sel == 2'd2) begin
                        rd_pend <= 1'b1;
                        rd_bank <= host_bank;
                    end
                    if (start) begin
                        state       <= S_STREAM;
                        step        <= '0;
                        err         <= 2'b00;
                        array_start <= 1'b1;
                    end
                end
                S_STREAM: begin
                    for (int i = 0; i < GRID; i++) begin
                        a_addr[i*AWIDTH +: AWIDTH] <= skew_addr(step, i);
                        b_addr[i*AWIDTH +: AWIDTH] <= skew_addr(step, i);
                    end
                    if (step == LAST_STEP) begin
                        state <= S_WAIT;
                        step  <= '0;
`ifdef MATMUL_GRID_WATCHDOG_EN
                        wdog  <= '0;
`endif
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (array_done) begin
                        state <= S_DRAIN;
                        step  <= '0;
                    end
`ifdef MATMUL_GRID_WATCHDOG_EN
                    else if (wdog == 10'h3ff) begin
                        state       <= S_IDLE;
                        array_start <= 1'b0;
                        err[1]      <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    for (int i = 0; i < GRID; i++) begin
                        c_we[i]                    <= skew_hit(step, i);
                        c_addr[i*AWIDTH +: AWIDTH] <= skew_addr(step, i);
                    end
                    if (step == LAST_STEP) begin
                        state       <= S_IDLE;
                        done        <= 1'b1;
                        array_start <= 1'b0;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_grid_mem_ctrl.sv
// Directed-random bench for matmul_grid_mem_ctrl at default parameters (GRID=2, MAT_SIZE=16).
module tb_matmul_grid_mem_ctrl;

    localparam int DW = 8;
    localparam int MS = 16;
    localparam int AW = 7;
    localparam int G  = 2;
    localparam int W  = MS * DW;
    localparam int NS = MS + G - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [1:0]      err;
    logic            host_we;
    logic [1:0]      host_sel;
    logic [0:0]      host_bank;
    logic [AW-1:0]   host_addr;
    logic [W-1:0]    host_wdata;
    logic [W-1:0]    host_rdata;
    logic            host_rvalid;
    logic [G*AW-1:0] a_addr, b_addr, c_addr;
    logic [G-1:0]    a_we, b_we, c_we;
    logic [W-1:0]    mem_wdata;
    logic [G*W-1:0]  c_rdata;
    logic            array_start;
    logic            array_done;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;

    logic [AW-1:0] sched [G][NS];
    logic          hit   [G][NS];

    matmul_grid_mem_ctrl #(.DWIDTH(DW), .MAT_SIZE(MS), .AWIDTH(AW), .GRID(G)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .host_we(host_we), .host_sel(host_sel), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .a_we(a_we), .b_we(b_we), .c_we(c_we),
        .mem_wdata(mem_wdata), .c_rdata(c_rdata), .array_start(array_start), .array_done(array_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [G*AW-1:0] one_addr(input int bank, input logic [AW-1:0] addr);
        logic [G*AW-1:0] v;
        v = '1;
        v[bank*AW +: AW] = addr;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 2'b00);
        chk({tag, "_astart"}, array_start, 1'b0);
        chk({tag, "_rvalid"}, host_rvalid, 1'b0);
        chk({tag, "_rdata"}, host_rdata, '0);
        chk({tag, "_we"}, {a_we, b_we, c_we}, '0);
        chk({tag, "_addr"}, {a_addr, b_addr, c_addr}, {3*G*AW{1'b1}});
    endtask

    // Checks one full STREAM phase; optionally injects a host write at step 3.
    task automatic stream_phase(input bit inject);
        logic [G*AW-1:0] ev;
        for (int j = 0; j < NS; j++) begin
            if (inject && j == 3) begin
                host_we = 1'b1; host_sel = 2'd0; host_bank = 1'b0; host_addr = 7'd1;
            end
            tick();
            if (inject && j == 3) begin
                host_we = 1'b0; host_sel = 2'd3;
                chk("busy_write_ignored", {a_we, b_we}, '0);
                chk("busy_write_err", err, 2'b01);
            end
            for (int b = 0; b < G; b++) ev[b*AW +: AW] = sched[b][j];
            chk("stream_a_addr", a_addr, ev);
            chk("stream_b_addr", b_addr, ev);
        end
        chk("wait_busy", busy, 1'b1);
        chk("wait_astart", array_start, 1'b1);
    endtask

    initial begin
        logic [W-1:0]    wd, d0, d1;
        logic [G*AW-1:0] ev;
        logic [G-1:0]    ewe;
        int              sel, bank, addr, n;

        // Bank b consumes row r at global step b+r; every other step is idle (all ones).
        for (int b = 0; b < G; b++)
            for (int s = 0; s < NS; s++) begin
                sched[b][s] = '1;
                hit[b][s]   = 1'b0;
            end
        for (int b = 0; b < G; b++)
            for (int r = 0; r < MS; r++) begin
                sched[b][b + r] = AW'(r);
                hit[b][b + r]   = 1'b1;
            end

        reset = 1'b0; start = 1'b0; host_we = 1'b0; host_sel = 2'd3; host_bank = '0;
        host_addr = '0; host_wdata = '0; c_rdata = '0; array_done = 1'b0;
        #12;
        check_reset_vals("reset");
        reset = 1'b1;
        tick();
        tick();

        // Host write A bank1 addr5
        wd = rnd_word();
        wd[7:0] = 8'hA5;
        host_we = 1'b1; host_sel = 2'd0; host_bank = 1'b1; host_addr = 7'd5; host_wdata = wd;
        tick();
        host_we = 1'b0; host_sel = 2'd3;
        chk("wr_a_we", a_we, 2'b10);
        chk("wr_b_we", b_we, 2'b00);
        chk("wr_a_addr", a_addr, one_addr(1, 7'd5));
        chk("wr_wdata", mem_wdata, wd);

        for (int k = 0; k < 6; k++) begin
            sel  = $urandom_range(0, 1);
            bank = $urandom_range(0, G - 1);
            addr = $urandom_range(0, (1 << AW) - 1);
            wd   = rnd_word();
            host_we = 1'b1; host_sel = 2'(sel); host_bank = 1'(bank);
            host_addr = AW'(addr); host_wdata = wd;
            tick();
            host_we = 1'b0; host_sel = 2'd3;
            ewe = '0;
            ewe[bank] = 1'b1;
            chk("rw_a_we", a_we, (sel == 0) ? ewe : '0);
            chk("rw_b_we", b_we, (sel == 1) ? ewe : '0);
            chk("rw_a_addr", a_addr, (sel == 0) ? one_addr(bank, AW'(addr)) : {G*AW{1'b1}});
            chk("rw_b_addr", b_addr, (sel == 1) ? one_addr(bank, AW'(addr)) : {G*AW{1'b1}});
            chk("rw_wdata", mem_wdata, wd);
        end

        // C readback bank1 addr3
        d1 = rnd_word();
        d1[W-1 -: 16] = 16'h1234;
        c_rdata = {d1, {W{1'b1}}};
        host_sel = 2'd2; host_bank = 1'b1; host_addr = 7'd3;
        tick();
        host_sel = 2'd3;
        chk("rb_c_addr", c_addr, one_addr(1, 7'd3));
        chk("rb_early_rvalid", host_rvalid, 1'b0);
        tick();
        chk("rb_rvalid", host_rvalid, 1'b1);
        chk("rb_rdata", host_rdata, d1);
        tick();
        chk("rb_rvalid_drop", host_rvalid, 1'b0);

        for (int k = 0; k < 4; k++) begin
            d0 = rnd_word(); d1 = rnd_word();
            c_rdata = {d1, d0};
            bank = $urandom_range(0, G - 1);
            addr = $urandom_range(0, (1 << AW) - 1);
            host_sel = 2'd2; host_bank = 1'(bank); host_addr = AW'(addr);
            tick();
            host_sel = 2'd3;
            chk("rrb_c_addr", c_addr, one_addr(bank, AW'(addr)));
            tick();
            chk("rrb_rvalid", host_rvalid, 1'b1);
            chk("rrb_rdata", host_rdata, (bank == 1) ? d1 : d0);
        end
        tick();

        // Run 1: start together with a B write; busy write during STREAM
        wd = rnd_word();
        start = 1'b1; host_we = 1'b1; host_sel = 2'd1; host_bank = 1'b0; host_addr = 7'd9; host_wdata = wd;
        tick();
        start = 1'b0; host_we = 1'b0; host_sel = 2'd3;
        chk("run1_busy", busy, 1'b1);
        chk("run1_astart", array_start, 1'b1);
        chk("run1_b_we", b_we, 2'b01);
        chk("run1_b_addr", b_addr, one_addr(0, 7'd9));
        stream_phase(1'b1);
        repeat (29) tick();
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        chk("drain_entry_c_we", c_we, 2'b00);
        for (int j = 0; j < NS; j++) begin
            tick();
            for (int b = 0; b < G; b++) begin
                ev[b*AW +: AW] = sched[b][j];
                ewe[b] = hit[b][j];
            end
            chk("drain_c_we", c_we, ewe);
            chk("drain_c_addr", c_addr, ev);
            chk("drain_done", done, (j == NS - 1) ? 1'b1 : 1'b0);
        end
        chk("end_busy", busy, 1'b0);
        chk("end_astart", array_start, 1'b0);
        tick();
        chk("done_pulse_one", done, 1'b0);
        chk("done_count", done_cnt, 1);
        chk("err_sticky", err, 2'b01);

        // Run 2: start clears err, then reset mid-WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run2_err_clear", err, 2'b00);
        stream_phase(1'b0);
        n = $urandom_range(1, 40);
        repeat (n) tick();
        #2 reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        #2 reset = 1'b1;
        tick();
        chk("midrst_idle", busy, 1'b0);
        chk("midrst_no_done", done_cnt, 1);

        // Run 3: array_done never arrives
        start = 1'b1;
        tick();
        start = 1'b0;
        stream_phase(1'b0);
`ifdef MATMUL_GRID_WATCHDOG_EN
        repeat (1023) tick();
        chk("wdog_still_busy", busy, 1'b1);
        tick();
        chk("wdog_idle", busy, 1'b0);
        chk("wdog_err", err, 2'b10);
        chk("wdog_astart", array_start, 1'b0);
        tick();
        chk("wdog_no_done", done_cnt, 1);
`else
        repeat (2000) tick();
        chk("nowdog_busy", busy, 1'b1);
        chk("nowdog_astart", array_start, 1'b1);
        chk("nowdog_err", err, 2'b00);
        chk("nowdog_no_done", done_cnt, 1);
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        tick();
        chk("nowdog_reset_idle", busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
